// File: rtl/seg_capture_decoder.sv
// seg_capture_decoder
// Monitors a time-multiplexed, active-low 7-segment bus and recovers the hex
// nibble shown on each digit. A digit/segment pattern must be sampled
// identically on STABLE consecutive clock edges before it is committed, so
// ghosting during anode switching never reaches the outputs.
module seg_capture_decoder #(
  parameter int NDIG   = 4,
  parameter int STABLE = 4,
  parameter int IDXW   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NDIG-1:0]       an,
  input  logic [6:0]            seg,
  output logic [4*NDIG-1:0]     digits,
  output logic [NDIG-1:0]       dvalid,
  output logic [NDIG-1:0]       blank,
  output logic                  upd,
  output logic [IDXW-1:0]       upd_idx,
  output logic                  err
);

  // Stability counter only has to reach STABLE, then it saturates.
  localparam int CW = $clog2(STABLE + 1);
  localparam logic [CW-1:0] STABLE_C = CW'(STABLE);
  localparam logic [6:0]    SEG_BLANK = 7'h7F;

  // Segment pattern {g,f,e,d,c,b,a} (active-low) to {legal, nibble}.
  function automatic logic [4:0] seg_decode(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'h40:   r = {1'b1, 4'h0};
      7'h79:   r = {1'b1, 4'h1};
      7'h24:   r = {1'b1, 4'h2};
      7'h30:   r = {1'b1, 4'h3};
      7'h19:   r = {1'b1, 4'h4};
      7'h12:   r = {1'b1, 4'h5};
      7'h02:   r = {1'b1, 4'h6};
      7'h78:   r = {1'b1, 4'h7};
      7'h00:   r = {1'b1, 4'h8};
      7'h10:   r = {1'b1, 4'h9};
      7'h08:   r = {1'b1, 4'hA};
      7'h03:   r = {1'b1, 4'hB};
      7'h46:   r = {1'b1, 4'hC};
      7'h21:   r = {1'b1, 4'hD};
      7'h06:   r = {1'b1, 4'hE};
      7'h0E:   r = {1'b1, 4'hF};
      default: r = 5'b0_0000;
    endcase
    return r;
  endfunction

  // A select is usable only when exactly one anode is driven low.
  function automatic logic sel_valid(input logic [NDIG-1:0] a);
    logic [NDIG-1:0] low;
    low = ~a;
    return (low != '0) && ((low & (low - NDIG'(1))) == '0);
  endfunction

  // Position of the low anode; only meaningful when sel_valid() holds.
  function automatic logic [IDXW-1:0] sel_index(input logic [NDIG-1:0] a);
    logic [IDXW-1:0] idx;
    idx = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (!a[i]) idx = IDXW'(i);
    end
    return idx;
  endfunction

  logic [NDIG-1:0]   prev_an_q,  prev_an_d;
  logic [6:0]        prev_seg_q, prev_seg_d;
  logic [CW-1:0]     cnt_q,      cnt_d;
  logic [4*NDIG-1:0] digits_q,   digits_d;
  logic [NDIG-1:0]   dvalid_q,   dvalid_d;
  logic [NDIG-1:0]   blank_q,    blank_d;
  logic              upd_q,      upd_d;
  logic [IDXW-1:0]   upd_idx_q,  upd_idx_d;
  logic              err_q,      err_d;

  logic              valid;
  logic              same;
  logic              commit;
  logic [IDXW-1:0]   k;
  logic [4:0]        dec;

  // Next-state: stability tracking, commit detection and per-digit update.
  always_comb begin
    prev_an_d  = an;
    prev_seg_d = seg;
    cnt_d      = '0;
    digits_d   = digits_q;
    dvalid_d   = dvalid_q;
    blank_d    = blank_q;
    upd_d      = 1'b0;
    upd_idx_d  = upd_idx_q;
    err_d      = 1'b0;

    valid = sel_valid(an);
    k     = sel_index(an);
    same  = (an == prev_an_q) && (seg == prev_seg_q);
    dec   = seg_decode(seg);

    // Idle or multi-select leaves the counter at zero.
    if (valid) begin
      if (!same)                  cnt_d = CW'(1);
      else if (cnt_q == STABLE_C) cnt_d = cnt_q;
      else                        cnt_d = cnt_q + CW'(1);
    end

    // Commit only on the edge the counter reaches STABLE, not while it
    // sits saturated there (a change re-arms it, which covers STABLE=1).
    commit = valid && (cnt_d == STABLE_C) && (!same || (cnt_q != STABLE_C));

    if (commit) begin
      upd_d     = 1'b1;
      upd_idx_d = k;
      if (dec[4]) begin
        digits_d[4*int'(k) +: 4] = dec[3:0];
        dvalid_d[k]              = 1'b1;
        blank_d[k]               = 1'b0;
      end else if (seg == SEG_BLANK) begin
        dvalid_d[k] = 1'b0;
        blank_d[k]  = 1'b1;
      end else begin
        err_d       = 1'b1;
        dvalid_d[k] = 1'b0;
        blank_d[k]  = 1'b0;
      end
    end
  end

  // State registers; reset returns the previous sample to the idle pattern.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_an_q  <= '1;
      prev_seg_q <= '1;
      cnt_q      <= '0;
      digits_q   <= '0;
      dvalid_q   <= '0;
      blank_q    <= '0;
      upd_q      <= 1'b0;
      upd_idx_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      prev_an_q  <= prev_an_d;
      prev_seg_q <= prev_seg_d;
      cnt_q      <= cnt_d;
      digits_q   <= digits_d;
      dvalid_q   <= dvalid_d;
      blank_q    <= blank_d;
      upd_q      <= upd_d;
      upd_idx_q  <= upd_idx_d;
      err_q      <= err_d;
    end
  end

  assign digits  = digits_q;
  assign dvalid  = dvalid_q;
  assign blank   = blank_q;
  assign upd     = upd_q;
  assign upd_idx = upd_idx_q;
  assign err     = err_q;

endmodule

// File: tb/tb_seg_capture_decoder.sv
// Bench for seg_capture_decoder: hand sequences for reset behaviour, a table
// of directed holds, then randomized holds against a history-based model.
module tb_seg_capture_decoder;

  localparam int NDIG   = 4;
  localparam int STABLE = 4;
  localparam int IDXW   = 2;

  logic        clk;
  logic        rst;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic [15:0] digits;
  logic [3:0]  dvalid;
  logic [3:0]  blank;
  logic        upd;
  logic [1:0]  upd_idx;
  logic        err;

  int checks;
  int failures;

  seg_capture_decoder #(.NDIG(NDIG), .STABLE(STABLE), .IDXW(IDXW)) dut (
    .clk(clk), .rst(rst), .an(an), .seg(seg),
    .digits(digits), .dvalid(dvalid), .blank(blank),
    .upd(upd), .upd_idx(upd_idx), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [6:0]  codes [16];
  logic [10:0] hist [$];
  logic [15:0] m_digits;
  logic [3:0]  m_dvalid, m_blank;
  logic        m_upd, m_err;
  logic [1:0]  m_idx;

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i <= STABLE; i++) hist.push_back(11'h7FF);
    m_digits = '0; m_dvalid = '0; m_blank = '0;
    m_upd = 1'b0; m_err = 1'b0; m_idx = '0;
  endtask

  // A commit happens when the newest STABLE samples are one identical valid
  // select and the sample just before that run was something else.
  task automatic model_edge();
    logic [10:0] s;
    logic        run;
    int          k, n;
    s = {an, seg};
    hist.push_back(s);
    void'(hist.pop_front());
    m_upd = 1'b0;
    m_err = 1'b0;
    if ($countones(~an) == 1) begin
      run = (hist[0] != s);
      for (int i = 1; i <= STABLE; i++) if (hist[i] != s) run = 1'b0;
      if (run) begin
        k = 0;
        for (int i = 0; i < NDIG; i++) if (!an[i]) k = i;
        n = -1;
        for (int i = 0; i < 16; i++) if (codes[i] == seg) n = i;
        m_upd = 1'b1;
        m_idx = 2'(k);
        if (n >= 0) begin
          m_digits[4*k +: 4] = 4'(n);
          m_dvalid[k] = 1'b1;
          m_blank[k]  = 1'b0;
        end else if (seg == 7'h7F) begin
          m_dvalid[k] = 1'b0;
          m_blank[k]  = 1'b1;
        end else begin
          m_err = 1'b1;
          m_dvalid[k] = 1'b0;
          m_blank[k]  = 1'b0;
        end
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("m_digits", 32'(digits), 32'(m_digits));
    chk("m_dvalid", 32'(dvalid), 32'(m_dvalid));
    chk("m_blank",  32'(blank),  32'(m_blank));
    chk("m_upd",    32'(upd),    32'(m_upd));
    chk("m_err",    32'(err),    32'(m_err));
    if (m_upd) chk("m_upd_idx", 32'(upd_idx), 32'(m_idx));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n,
                      output int nupd, output int nerr, output logic [1:0] lidx);
    an = a; seg = s;
    nupd = 0; nerr = 0; lidx = '0;
    for (int i = 0; i < n; i++) begin
      step();
      if (upd) begin nupd++; lidx = upd_idx; end
      if (err) begin
        nerr++;
        chk("err_with_upd", 32'(upd), 32'd1);
      end
    end
  endtask

  typedef struct {
    logic [3:0]  an;
    logic [6:0]  seg;
    int          n;
    logic [15:0] e_digits;
    logic [3:0]  e_dvalid;
    logic [3:0]  e_blank;
    int          e_upd;
    int          e_err;
    logic [1:0]  e_idx;
  } vec_t;

  vec_t tbl [12];

  initial begin
    int nu, ne;
    logic [1:0] li;
    logic [3:0] ra;
    logic [6:0] rs;
    int r;

    checks = 0; failures = 0;
    codes = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    tbl[0]  = '{4'hE, 7'h12,  6, 16'h0005, 4'h1, 4'h0, 1, 0, 2'd0};
    tbl[1]  = '{4'hD, 7'h08,  6, 16'h00A5, 4'h3, 4'h0, 1, 0, 2'd1};
    tbl[2]  = '{4'hB, 7'h46,  6, 16'h0CA5, 4'h7, 4'h0, 1, 0, 2'd2};
    tbl[3]  = '{4'h7, 7'h40,  6, 16'h0CA5, 4'hF, 4'h0, 1, 0, 2'd3};
    tbl[4]  = '{4'hD, 7'h24,  3, 16'h0CA5, 4'hF, 4'h0, 0, 0, 2'd0};
    tbl[5]  = '{4'hD, 7'h79,  5, 16'h0C15, 4'hF, 4'h0, 1, 0, 2'd1};
    tbl[6]  = '{4'hB, 7'h7F,  6, 16'h0C15, 4'hB, 4'h4, 1, 0, 2'd2};
    tbl[7]  = '{4'hB, 7'h55,  6, 16'h0C15, 4'hB, 4'h0, 1, 1, 2'd2};
    tbl[8]  = '{4'hF, 7'h00,  4, 16'h0C15, 4'hB, 4'h0, 0, 0, 2'd0};
    tbl[9]  = '{4'hC, 7'h40, 10, 16'h0C15, 4'hB, 4'h0, 0, 0, 2'd0};
    tbl[10] = '{4'h7, 7'h0E, 20, 16'hFC15, 4'hB, 4'h0, 1, 0, 2'd3};
    tbl[11] = '{4'h7, 7'h06,  4, 16'hEC15, 4'hB, 4'h0, 1, 0, 2'd3};

    // Power-on reset.
    rst = 1'b1; an = 4'hF; seg = 7'h7F;
    model_reset();
    #23;
    chk("rst_digits", 32'(digits), 32'h0);
    chk("rst_dvalid", 32'(dvalid), 32'h0);
    chk("rst_blank",  32'(blank),  32'h0);
    chk("rst_upd",    32'(upd),    32'h0);
    chk("rst_err",    32'(err),    32'h0);
    chk("rst_idx",    32'(upd_idx), 32'h0);
    @(negedge clk); rst = 1'b0;

    // First commit lands exactly on the 4th edge.
    an = 4'hE; seg = 7'h30;
    for (int i = 1; i <= 6; i++) begin
      step();
      chk("first_upd_edge", 32'(upd), (i == STABLE) ? 32'd1 : 32'd0);
    end
    chk("first_digit", 32'(digits), 32'h3);

    // Partial run, then asynchronous reset between edges.
    seg = 7'h79;
    step(); step();
    #2; rst = 1'b1; #1;
    chk("async_digits", 32'(digits), 32'h0);
    chk("async_dvalid", 32'(dvalid), 32'h0);
    chk("async_upd",    32'(upd),    32'h0);
    model_reset();
    @(negedge clk); @(negedge clk); rst = 1'b0;

    // Fresh run required after release.
    an = 4'hE; seg = 7'h30;
    for (int i = 1; i <= 6; i++) begin
      step();
      chk("post_rst_upd_edge", 32'(upd), (i == STABLE) ? 32'd1 : 32'd0);
      if (upd) chk("post_rst_idx", 32'(upd_idx), 32'd0);
    end
    chk("post_rst_digits", 32'(digits), 32'h3);
    chk("post_rst_dvalid", 32'(dvalid), 32'h1);

    // Directed table.
    for (int v = 0; v < 12; v++) begin
      hold(tbl[v].an, tbl[v].seg, tbl[v].n, nu, ne, li);
      chk($sformatf("tbl%0d_upd_count", v), 32'(nu), 32'(tbl[v].e_upd));
      chk($sformatf("tbl%0d_err_count", v), 32'(ne), 32'(tbl[v].e_err));
      chk($sformatf("tbl%0d_digits", v), 32'(digits), 32'(tbl[v].e_digits));
      chk($sformatf("tbl%0d_dvalid", v), 32'(dvalid), 32'(tbl[v].e_dvalid));
      chk($sformatf("tbl%0d_blank", v), 32'(blank), 32'(tbl[v].e_blank));
      if (tbl[v].e_upd > 0) chk($sformatf("tbl%0d_idx", v), 32'(li), 32'(tbl[v].e_idx));
    end

    // Randomized holds against the model.
    for (int h = 0; h < 400; h++) begin
      r = int'($urandom_range(0, 8));
      if (r <= 6)      ra = ~(4'b0001 << $urandom_range(0, NDIG - 1));
      else if (r == 7) ra = 4'hF;
      else             ra = ~((4'b0001 << $urandom_range(0, 3)) | (4'b0001 << $urandom_range(0, 3)) | 4'b0100);
      r = int'($urandom_range(0, 11));
      if (r <= 9)       rs = codes[$urandom_range(0, 15)];
      else if (r == 10) rs = 7'h7F;
      else              rs = 7'($urandom);
      hold(ra, rs, int'($urandom_range(1, 7)), nu, ne, li);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
